// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core boot sequencer.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RST_HOLD = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_STOP     = 3'd5
    } boot_state_e;

    localparam int RST_HOLD_CYCLES_DEF = 6;
    localparam int DRAIN_CYCLES_DEF    = 2;
    localparam int WDOG_CYCLES_DEF     = 1000;

    // Width of a boot address; matches the memory word width of the image loader.
    localparam int MEM_WORD_WIDTH = 32;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/up_counter.sv
// Saturating up-counter with synchronous clear; used as the core watchdog.
module up_counter #(
    parameter int INCREMENT_RATE = 1,
    parameter int WIDTH          = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count_val
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(INCREMENT_RATE);

    // Clear wins over counting; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_val <= '0;
        end else if (clear) begin
            count_val <= '0;
        end else if (en) begin
            if (count_val > (CNT_MAX - STEP)) begin
                count_val <= CNT_MAX;
            end else begin
                count_val <= count_val + STEP;
            end
        end
    end

endmodule

// File: rtl/core_boot_ctrl.sv
// Bring-up sequencer for the core: image load handshake, clock enable with
// reset stretch, supervised run, then drain-on-halt or gate-off on watchdog.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | out of reset, waiting for start
// LOAD      | load_req high, waiting for the loader's load_ack
// RST_HOLD  | core clock running, core reset held for RST_HOLD_CYCLES
// RUN       | core released, watchdog counting
// DRAIN     | core halted, clock kept on for DRAIN_CYCLES
// STOP      | clock gated, done/timeout reported, waiting for restart
module core_boot_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF,
    parameter int DRAIN_CYCLES    = DRAIN_CYCLES_DEF,
    parameter int WDOG_CYCLES     = WDOG_CYCLES_DEF,
    parameter int WDOG_W          = $clog2(WDOG_CYCLES),
    parameter int ADDR_W          = MEM_WORD_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              load_req,
    input  logic              load_ack,
    output logic              cg_clk_en,
    output logic              core_rstn,
    output logic [ADDR_W-1:0] boot_addr,
    input  logic              core_halt,
    input  logic              wdog_kick,
    output logic [WDOG_W-1:0] wdog_count,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state_o
);

    localparam int HOLD_MAX = (RST_HOLD_CYCLES > DRAIN_CYCLES) ? RST_HOLD_CYCLES : DRAIN_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    localparam logic [HOLD_W-1:0] HOLD_RST_LOAD   = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_DRAIN_LOAD = HOLD_W'(DRAIN_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST       = WDOG_W'(WDOG_CYCLES - 1);

    boot_state_e       state_q;
    boot_state_e       state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic              start_ok;
    logic              wdog_expired;
    logic              wdog_en;
    logic              wdog_clear;

    assign start_ok     = start && ((state_q == ST_IDLE) || (state_q == ST_STOP));
    assign wdog_expired = (wdog_count == WDOG_LAST);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in RUN a halt beats expiry and a kick defers it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_STOP: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_ack && load_req) begin
                    state_d = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_halt) begin
                    state_d = ST_DRAIN;
                end else if (!wdog_kick && wdog_expired) begin
                    state_d = ST_STOP;
                end
            end
            ST_DRAIN: begin
                if (hold_cnt == '0) begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One down-counter times both the reset stretch and the drain; loaded on entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= '0;
        end else if ((state_d == ST_RST_HOLD) && (state_q != ST_RST_HOLD)) begin
            hold_cnt <= HOLD_RST_LOAD;
        end else if ((state_d == ST_DRAIN) && (state_q != ST_DRAIN)) begin
            hold_cnt <= HOLD_DRAIN_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Registered outputs decoded from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_req  <= 1'b0;
            cg_clk_en <= 1'b0;
            core_rstn <= 1'b0;
            boot_addr <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            load_req  <= (state_d == ST_LOAD);
            cg_clk_en <= (state_d == ST_RST_HOLD) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
            core_rstn <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            if (start_ok) begin
                boot_addr <= start_addr;
                done      <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                if ((state_q == ST_DRAIN) && (state_d == ST_STOP)) begin
                    done <= 1'b1;
                end
                if ((state_q == ST_RUN) && (state_d == ST_STOP)) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    // The watchdog only advances while the run continues, so the value that
    // ended the run (halt or expiry) is the one left on wdog_count.
    assign wdog_en    = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign wdog_clear = ((state_q == ST_RUN) && wdog_kick) ||
                        ((state_d == ST_RUN) && (state_q != ST_RUN));

    up_counter #(
        .INCREMENT_RATE (1),
        .WIDTH          (WDOG_W)
    ) u_wdog (
        .clk       (clk),
        .rstn      (rstn),
        .en        (wdog_en),
        .clear     (wdog_clear),
        .count_val (wdog_count)
    );

    assign state_o = state_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Self-checking bench for core_boot_ctrl with directed and randomized runs.
module tb_core_boot_ctrl;

    localparam int WDOG     = 1000;
    localparam int RST_HOLD = 6;
    localparam int DRAIN    = 2;
    localparam int MAXT     = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic        load_ack = 1'b0;
    logic        core_halt = 1'b0;
    logic        wdog_kick = 1'b0;
    logic        load_req;
    logic        cg_clk_en;
    logic        core_rstn;
    logic [31:0] boot_addr;
    logic [9:0]  wdog_count;
    logic        done;
    logic        timeout;
    logic [2:0]  state_o;

    int n_cmp = 0;
    int n_bad = 0;

    bit          kick_at[MAXT];
    int          halt_at;
    int          start_pulse_at;
    logic [31:0] cur_addr;

    core_boot_ctrl #(
        .RST_HOLD_CYCLES (RST_HOLD),
        .DRAIN_CYCLES    (DRAIN),
        .WDOG_CYCLES     (WDOG)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .start_addr (start_addr),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .cg_clk_en  (cg_clk_en),
        .core_rstn  (core_rstn),
        .boot_addr  (boot_addr),
        .core_halt  (core_halt),
        .wdog_kick  (wdog_kick),
        .wdog_count (wdog_count),
        .done       (done),
        .timeout    (timeout),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < MAXT; i++) kick_at[i] = 1'b0;
        halt_at        = -1;
        start_pulse_at = -1;
    endtask

    // Start from IDLE/STOP, answer the load request after ack_dly cycles and
    // follow the reset stretch; returns at cycle 0 of RUN (#1 after entry edge).
    task automatic boot(input logic [31:0] addr, input int ack_dly);
        int n;
        cur_addr   = addr;
        start      = 1'b1;
        start_addr = addr;
        tick();
        start      = 1'b0;
        start_addr = $urandom;
        chk("load_req_rise", load_req, 1);
        chk("state_load", state_o, 1);
        chk("done_cleared", done, 0);
        chk("timeout_cleared", timeout, 0);
        chk("boot_addr", boot_addr, addr);
        for (int i = 0; i < ack_dly; i++) begin
            chk("load_req_hold", load_req, 1);
            chk("cg_before_ack", cg_clk_en, 0);
            tick();
        end
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        chk("load_req_fall", load_req, 0);
        chk("cg_on_ack_edge", cg_clk_en, 1);
        chk("core_rstn_held", core_rstn, 0);
        chk("state_rst_hold", state_o, 2);
        n = 0;
        while (core_rstn !== 1'b1 && n < 20) begin
            chk("cg_during_hold", cg_clk_en, 1);
            tick();
            n++;
        end
        chk("rst_hold_len", n, RST_HOLD);
        chk("state_run", state_o, 3);
        chk("wdog_entry", wdog_count, 0);
        chk("boot_addr_run", boot_addr, addr);
    endtask

    // Drive one RUN phase from the schedule. The reference is the rule set:
    // count(t) = t - (cycle after last kick); halt ends the run first, a kick
    // restarts the count, otherwise reaching WDOG-1 ends it with a timeout.
    task automatic run_phase();
        int   base;
        int   t;
        int   exp_cnt;
        int   fc;
        bit   ended;
        bit   by_halt;
        bit   k;
        bit   h;
        base    = 0;
        t       = 0;
        ended   = 1'b0;
        by_halt = 1'b0;
        fc      = 0;
        while (!ended && t < MAXT) begin
            exp_cnt = t - base;
            chk("wdog_count_run", wdog_count, exp_cnt);
            k          = kick_at[t];
            h          = (t == halt_at);
            wdog_kick  = k;
            core_halt  = h;
            start      = (t == start_pulse_at);
            start_addr = $urandom;
            tick();
            wdog_kick = 1'b0;
            core_halt = 1'b0;
            start     = 1'b0;
            if (h) begin
                ended   = 1'b1;
                by_halt = 1'b1;
                fc      = k ? 0 : exp_cnt;
            end else if (k) begin
                base = t + 1;
                chk("stay_run_kick", state_o, 3);
            end else if (exp_cnt == WDOG - 1) begin
                ended = 1'b1;
                fc    = exp_cnt;
            end else begin
                chk("stay_run", state_o, 3);
            end
            t++;
        end
        if (!ended) begin
            chk("run_bound", 0, 1);
            return;
        end
        if (by_halt) begin
            chk("state_drain", state_o, 4);
            chk("cg_drain", cg_clk_en, 1);
            chk("core_rstn_drain", core_rstn, 1);
            chk("wdog_frozen", wdog_count, fc);
            for (int i = 0; i < DRAIN - 1; i++) begin
                tick();
                chk("state_drain_n", state_o, 4);
                chk("cg_drain_n", cg_clk_en, 1);
                chk("done_not_yet", done, 0);
            end
            tick();
            chk("state_stop", state_o, 5);
            chk("cg_off_halt", cg_clk_en, 0);
            chk("core_rstn_stop", core_rstn, 0);
            chk("done_set", done, 1);
            chk("timeout_clear", timeout, 0);
            chk("wdog_final", wdog_count, fc);
        end else begin
            chk("state_stop_to", state_o, 5);
            chk("cg_off_to", cg_clk_en, 0);
            chk("core_rstn_to", core_rstn, 0);
            chk("timeout_set", timeout, 1);
            chk("done_clear", done, 0);
            chk("wdog_final_to", wdog_count, fc);
        end
        repeat (3) tick();
        chk("stop_hold_state", state_o, 5);
        chk("stop_hold_done", done, by_halt);
        chk("stop_hold_timeout", timeout, !by_halt);
        chk("stop_hold_wdog", wdog_count, fc);
        chk("boot_addr_stable", boot_addr, cur_addr);
    endtask

    initial begin
        int tk;
        clear_sched();
        #12;
        chk("rst_state", state_o, 0);
        chk("rst_load_req", load_req, 0);
        chk("rst_cg", cg_clk_en, 0);
        chk("rst_core_rstn", core_rstn, 0);
        chk("rst_boot_addr", boot_addr, 0);
        chk("rst_wdog", wdog_count, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("idle_after_rst", state_o, 0);

        // halt at count 50
        boot(32'h0000_1000, 3);
        clear_sched();
        halt_at = 50;
        run_phase();

        // free-running to timeout, with a start pulse in RUN that must be ignored
        boot($urandom, $urandom_range(0, 5));
        clear_sched();
        start_pulse_at = 37;
        run_phase();

        // kick every 500 cycles for 3000 cycles, then halt
        boot($urandom, 2);
        clear_sched();
        for (int i = 499; i < 3000; i += 500) kick_at[i] = 1'b1;
        halt_at = 3000;
        run_phase();

        // kick coincident with count 999, then halt coincident with expiry
        boot($urandom, 1);
        clear_sched();
        kick_at[999] = 1'b1;
        halt_at = 1999;
        run_phase();

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            boot($urandom, $urandom_range(0, 5));
            clear_sched();
            tk = $urandom_range(100, 1100);
            while (tk < 3000) begin
                kick_at[tk] = 1'b1;
                tk += $urandom_range(200, 1100);
            end
            if ($urandom_range(0, 1) == 1) halt_at = $urandom_range(50, 3000);
            if ($urandom_range(0, 1) == 1) start_pulse_at = $urandom_range(0, 40);
            run_phase();
        end

        // reset at cycle 20 of RUN takes effect immediately
        boot($urandom, 2);
        repeat (20) tick();
        rstn = 1'b0;
        #1;
        chk("amid_state", state_o, 0);
        chk("amid_cg", cg_clk_en, 0);
        chk("amid_core_rstn", core_rstn, 0);
        chk("amid_done", done, 0);
        chk("amid_timeout", timeout, 0);
        chk("amid_wdog", wdog_count, 0);
        chk("amid_boot_addr", boot_addr, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("amid_idle", state_o, 0);

        // full sequence still works after the abort
        boot(32'hDEAD_0040, 4);
        clear_sched();
        halt_at = $urandom_range(10, 900);
        run_phase();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
